// File: rtl/bip_addsub_acc_if.sv
// Purpose : operation/result bundle between the BIP decoder, the add/sub accumulator and its consumers.
// Latency : not applicable; this is wiring only.
// Backpressure: none; in_valid is a fire-and-forget strobe and out_valid a one-cycle result pulse.
// Signals : in_valid/op/b/clr_ovf travel towards the accumulator; acc/out_valid/zero/neg/ovf/ovf_sticky travel back.
interface bip_addsub_acc_if #(
    parameter int N = 15
);
    logic         in_valid;
    logic [1:0]   op;
    logic [N:0]   b;
    logic         clr_ovf;
    logic [N:0]   acc;
    logic         out_valid;
    logic         zero;
    logic         neg;
    logic         ovf;
    logic         ovf_sticky;

    // Decoder side: issues operations, observes results.
    modport master (
        output in_valid, op, b, clr_ovf,
        input  acc, out_valid, zero, neg, ovf, ovf_sticky
    );

    // Accumulator side: consumes operations, produces results.
    modport slave (
        input  in_valid, op, b, clr_ovf,
        output acc, out_valid, zero, neg, ovf, ovf_sticky
    );
endinterface

// File: rtl/bip_addsub_acc.sv
// Purpose : registered signed LOAD/ADD/SUB/CLR accumulator with zero/neg/overflow flags and optional saturation.
// Latency : 1 cycle; acc, flags and the out_valid pulse appear on the edge after in_valid is sampled.
// Backpressure: none; an op is accepted on every cycle with in_valid high, back-to-back included.
// Ports   : clk, rst (async, active high); bus = bip_addsub_acc_if.slave carrying
//           in_valid, op, b, clr_ovf in and acc, out_valid, zero, neg, ovf, ovf_sticky out.
module bip_addsub_acc #(
    parameter int N   = 15,
    parameter bit SAT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    bip_addsub_acc_if.slave  bus
);

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    localparam logic [N:0] ACC_MAX = {1'b0, {N{1'b1}}};
    localparam logic [N:0] ACC_MIN = {1'b1, {N{1'b0}}};

    logic [N:0]   acc_q;
    logic [N:0]   acc_nxt;
    logic         out_valid_q;
    logic         zero_q;
    logic         neg_q;
    logic         ovf_q;
    logic         ovf_nxt;
    logic         ovf_hit;
    logic         sticky_q;

    logic [N+1:0] a_ext;
    logic [N+1:0] b_ext;
    logic [N+1:0] sum_ext;
    logic [N+1:0] dif_ext;

    // Sign-extend both operands one bit so the true result always fits.
    assign a_ext   = {acc_q[N], acc_q};
    assign b_ext   = {bus.b[N], bus.b};
    assign sum_ext = a_ext + b_ext;
    assign dif_ext = a_ext - b_ext;

    // Overflow is detected as the extended result not fitting in N+1 bits
    // (its top two bits disagree); this is equivalent to the operand/result
    // sign comparison for both ADD and SUB.
    always_comb begin
        acc_nxt = acc_q;
        ovf_nxt = ovf_q;
        ovf_hit = 1'b0;
        if (bus.in_valid) begin
            case (op_e'(bus.op))
                OP_LOAD: begin
                    acc_nxt = bus.b;
                    ovf_nxt = 1'b0;
                end
                OP_ADD: begin
                    ovf_hit = sum_ext[N+1] ^ sum_ext[N];
                    acc_nxt = sum_ext[N:0];
                    ovf_nxt = ovf_hit;
                end
                OP_SUB: begin
                    ovf_hit = dif_ext[N+1] ^ dif_ext[N];
                    acc_nxt = dif_ext[N:0];
                    ovf_nxt = ovf_hit;
                end
                default: begin
                    acc_nxt = '0;
                    ovf_nxt = 1'b0;
                end
            endcase
            // Saturation direction follows the sign of the old accumulator:
            // an overflow can only push a value past the rail on its own side.
            if (ovf_hit && SAT) begin
                acc_nxt = acc_q[N] ? ACC_MIN : ACC_MAX;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b1;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                acc_q  <= acc_nxt;
                zero_q <= (acc_nxt == '0);
                neg_q  <= acc_nxt[N];
                ovf_q  <= ovf_nxt;
            end
            // A fresh overflow takes priority over a simultaneous clear request.
            if (ovf_hit) begin
                sticky_q <= 1'b1;
            end else if (bus.clr_ovf) begin
                sticky_q <= 1'b0;
            end
        end
    end

    assign bus.acc        = acc_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.zero       = zero_q;
    assign bus.neg        = neg_q;
    assign bus.ovf        = ovf_q;
    assign bus.ovf_sticky = sticky_q;

endmodule

// File: tb/tb_bip_addsub_acc.sv
module tb_bip_addsub_acc;

    localparam int N    = 15;
    localparam int MAXI = 32767;
    localparam int MINI = -32768;
    localparam int SPAN = 65536;

    localparam logic [1:0] LD  = 2'b00;
    localparam logic [1:0] ADD = 2'b01;
    localparam logic [1:0] SUB = 2'b10;
    localparam logic [1:0] CLR = 2'b11;

    logic clk;
    logic rst;

    bip_addsub_acc_if #(.N(N)) if0 ();
    bip_addsub_acc_if #(.N(N)) if1 ();

    bip_addsub_acc #(.N(N), .SAT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    bip_addsub_acc #(.N(N), .SAT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    // Reference model: accumulator held as a plain integer per saturation mode.
    int m_acc [2];
    bit m_ovf [2];
    bit m_st  [2];
    bit m_ov;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_acc[s] = 0;
            m_ovf[s] = 1'b0;
            m_st[s]  = 1'b0;
        end
        m_ov = 1'b0;
    endtask

    task automatic model_edge(input bit v, input logic [1:0] o, input logic [15:0] bv, input bit c);
        int sb;
        int r;
        bit hit;
        sb = int'($signed(bv));
        for (int s = 0; s < 2; s++) begin
            hit = 1'b0;
            if (v) begin
                if (o == LD) begin
                    m_acc[s] = sb;
                    m_ovf[s] = 1'b0;
                end else if (o == CLR) begin
                    m_acc[s] = 0;
                    m_ovf[s] = 1'b0;
                end else begin
                    r = (o == ADD) ? m_acc[s] + sb : m_acc[s] - sb;
                    hit = (r > MAXI) || (r < MINI);
                    if (hit) begin
                        if (s == 1) r = (m_acc[s] >= 0) ? MAXI : MINI;
                        else if (r > MAXI) r = r - SPAN;
                        else r = r + SPAN;
                    end
                    m_acc[s] = r;
                    m_ovf[s] = hit;
                end
            end
            if (hit) m_st[s] = 1'b1;
            else if (c) m_st[s] = 1'b0;
        end
        m_ov = v;
    endtask

    task automatic chk_dut(input string tag, input int s, input logic [15:0] acc, input logic ov,
                           input logic z, input logic ng, input logic of, input logic st);
        logic [15:0] ea;
        ea = m_acc[s][15:0];
        chk({tag, "_acc"},  {16'h0, acc}, {16'h0, ea});
        chk({tag, "_oval"}, {31'h0, ov},  {31'h0, m_ov});
        chk({tag, "_zero"}, {31'h0, z},   {31'h0, (m_acc[s] == 0)});
        chk({tag, "_neg"},  {31'h0, ng},  {31'h0, (m_acc[s] < 0)});
        chk({tag, "_ovf"},  {31'h0, of},  {31'h0, m_ovf[s]});
        chk({tag, "_stky"}, {31'h0, st},  {31'h0, m_st[s]});
    endtask

    task automatic check_all(input string tag);
        chk_dut({tag, "_wrap"}, 0, if0.acc, if0.out_valid, if0.zero, if0.neg, if0.ovf, if0.ovf_sticky);
        chk_dut({tag, "_sat"},  1, if1.acc, if1.out_valid, if1.zero, if1.neg, if1.ovf, if1.ovf_sticky);
    endtask

    task automatic drive(input bit v, input logic [1:0] o, input logic [15:0] bv, input bit c);
        if0.in_valid = v;  if1.in_valid = v;
        if0.op       = o;  if1.op       = o;
        if0.b        = bv; if1.b        = bv;
        if0.clr_ovf  = c;  if1.clr_ovf  = c;
    endtask

    // Apply inputs, take one edge, advance the model, then check just after the edge.
    task automatic step(input string tag, input bit v, input logic [1:0] o, input logic [15:0] bv, input bit c);
        drive(v, o, bv, c);
        @(posedge clk);
        model_edge(v, o, bv, c);
        #1;
        check_all(tag);
    endtask

    function automatic logic [15:0] pick_b();
        logic [15:0] x;
        case ($urandom_range(0, 5))
            0: x = 16'h7FFF;
            1: x = 16'h8000;
            2: x = 16'h0000;
            3: x = 16'h0001;
            4: x = 16'hFFFF;
            default: x = 16'($urandom);
        endcase
        return x;
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        model_reset();
        rst = 1'b1;
        drive(1'b0, LD, 16'h0, 1'b0);
        #2;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1: basic sequence
        step("t1_load", 1'b1, LD,  16'h0005, 1'b0);
        step("t1_add",  1'b1, ADD, 16'h0003, 1'b0);
        chk("t1_acc8", {16'h0, if0.acc}, 32'h0008);
        step("t1_sub",  1'b1, SUB, 16'h000A, 1'b0);
        chk("t1_accm2", {16'h0, if0.acc}, 32'hFFFE);
        chk("t1_neg", {31'h0, if0.neg}, 32'h1);
        step("t1_idle", 1'b0, ADD, 16'h0000, 1'b0);

        // 2: positive overflow
        step("t2_load", 1'b1, LD,  16'h7FFF, 1'b0);
        step("t2_add",  1'b1, ADD, 16'h0001, 1'b0);
        chk("t2_wrap", {16'h0, if0.acc}, 32'h8000);
        chk("t2_sat",  {16'h0, if1.acc}, 32'h7FFF);

        // 3: 0 - (-2^N) overflows; LOAD clears ovf but not sticky; clr_ovf alone clears sticky
        step("t3_load0", 1'b1, LD,  16'h0000, 1'b0);
        step("t3_sub",   1'b1, SUB, 16'h8000, 1'b0);
        chk("t3_wrap", {16'h0, if0.acc}, 32'h8000);
        chk("t3_sat",  {16'h0, if1.acc}, 32'h7FFF);
        step("t3_load1", 1'b1, LD,  16'h0001, 1'b0);
        chk("t3_stky", {31'h0, if0.ovf_sticky}, 32'h1);
        step("t3_clr",   1'b0, LD,  16'h0000, 1'b1);
        chk("t3_stky0", {31'h0, if1.ovf_sticky}, 32'h0);

        // 4: overflow wins over same-cycle clr_ovf
        step("t4_load", 1'b1, LD,  16'h7FFF, 1'b0);
        step("t4_add",  1'b1, ADD, 16'h7FFF, 1'b1);
        chk("t4_stky", {31'h0, if0.ovf_sticky}, 32'h1);
        step("t4_add0", 1'b1, ADD, 16'h0000, 1'b1);

        // 5: CLR, then ignored ops while in_valid is low
        step("t5_load", 1'b1, LD,  16'h1234, 1'b0);
        step("t5_clr",  1'b1, CLR, 16'h1234, 1'b0);
        for (int i = 0; i < 3; i++) step("t5_hold", 1'b0, ADD, 16'h0005, 1'b0);
        chk("t5_zero", {31'h0, if0.zero}, 32'h1);

        // 6: asynchronous reset between edges
        step("t6_load", 1'b1, LD, 16'h4321, 1'b0);
        drive(1'b1, ADD, 16'h0011, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("t6_async");
        @(posedge clk);
        #1;
        check_all("t6_inrst");
        @(negedge clk);
        rst = 1'b0;
        step("t6_idle", 1'b0, ADD, 16'h0011, 1'b0);
        step("t6_first", 1'b1, ADD, 16'h0011, 1'b0);

        // Randomised traffic against the model
        for (int i = 0; i < 300; i++) begin
            step("rnd", ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), pick_b(),
                 ($urandom_range(0, 4) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
